// File: rtl/alu_mon_pkg.sv
// alu_mon_pkg: types and defaults for the ALU divergence monitor.
//   state_t  - monitor FSM states (IDLE, CHECK, ALARM)
//   flags_t  - ALU status flags {carry, zero, overflow}
//   DEF_THRESHOLD / DEF_WINDOW - default alarm threshold and window length
//   sat_inc4 - 4-bit saturating increment used by the window mismatch counter
package alu_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_ALARM = 2'd2
   } state_t;

   typedef struct packed {
      logic carry;
      logic zero;
      logic overflow;
   } flags_t;

   localparam int DEF_THRESHOLD = 4;
   localparam int DEF_WINDOW    = 256;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/alu_mon_window.sv
// alu_mon_window: observation-window bookkeeping for the divergence monitor.
//   clk, rst_n   - clock and synchronous active-low reset
//   clr          - clears window position and window mismatch count
//   sample_en    - one checked sample is being retired this cycle
//   diverge      - the retiring sample diverged
//   win_mis_upd  - mismatch count including the retiring sample, before any
//                  end-of-window clear (used for the alarm decision)
module alu_mon_window
   import alu_mon_pkg::*;
#(
   parameter int WINDOW = DEF_WINDOW
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       sample_en,
   input  logic       diverge,
   output logic [3:0] win_mis_upd
);

   localparam int             CW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WINDOW - 1);

   logic [CW-1:0] win_pos_r;
   logic [3:0]    win_mis_r;
   logic [3:0]    win_mis_upd_s;

   // Mismatch count as it stands once the retiring sample is included.
   always_comb begin
      win_mis_upd_s = win_mis_r;
      if (diverge) begin
         win_mis_upd_s = sat_inc4(win_mis_r);
      end else begin
         win_mis_upd_s = win_mis_r;
      end
   end

   assign win_mis_upd = win_mis_upd_s;

   // Window position and mismatch count; the count restarts after the last
   // sample of a window has been evaluated (WINDOW is a power of two, so the
   // position wraps naturally).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_pos_r <= '0;
         win_mis_r <= 4'd0;
      end else if (clr) begin
         win_pos_r <= '0;
         win_mis_r <= 4'd0;
      end else if (sample_en) begin
         win_pos_r <= win_pos_r + CW'(1);
         win_mis_r <= (win_pos_r == LAST) ? 4'd0 : win_mis_upd_s;
      end else begin
         win_pos_r <= win_pos_r;
         win_mis_r <= win_mis_r;
      end
   end

endmodule

// File: rtl/alu_divergence_monitor.sv
// alu_divergence_monitor: compares a suspect ALU against a golden ALU sample
// by sample and raises a sticky alarm when too many divergences fall inside
// one observation window.
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid / in_ready     - sample handshake (ready only in IDLE)
//   A, B, op                - operands and opcode of the sample
//   result_ref/result_dut   - golden / suspect results
//   flags_ref/flags_dut     - golden / suspect {carry, zero, overflow}
//   alarm_clr               - releases the alarm (ignored outside ALARM)
//   mismatch_pulse          - one-cycle pulse per divergent sample
//   alarm                   - sticky divergence alarm
//   mismatch_total          - saturating divergent-sample count
//   sample_total            - wrapping accepted-sample count
//   log_valid/log_A/B/op    - first-divergence record
// Optional feature macro: ALU_MON_LOG_EN enables the first-divergence record;
// without it the log_* outputs are tied to zero.
module alu_divergence_monitor
   import alu_mon_pkg::*;
#(
   parameter int THRESHOLD = DEF_THRESHOLD,
   parameter int WINDOW    = DEF_WINDOW
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  A,
   input  logic [3:0]  B,
   input  logic [1:0]  op,
   input  logic [3:0]  result_ref,
   input  logic [3:0]  result_dut,
   input  logic [2:0]  flags_ref,
   input  logic [2:0]  flags_dut,
   input  logic        alarm_clr,
   output logic        mismatch_pulse,
   output logic        alarm,
   output logic [7:0]  mismatch_total,
   output logic [15:0] sample_total,
   output logic        log_valid,
   output logic [3:0]  log_A,
   output logic [3:0]  log_B,
   output logic [1:0]  log_op
);

   state_t      state_r;
   logic        in_ready_r;
   logic        alarm_r;
   logic        mismatch_pulse_r;
   logic [7:0]  mismatch_total_r;
   logic [15:0] sample_total_r;
   logic [3:0]  a_r;
   logic [3:0]  b_r;
   logic [1:0]  op_r;
   logic [3:0]  res_ref_r;
   logic [3:0]  res_dut_r;
   flags_t      flags_ref_r;
   flags_t      flags_dut_r;

   logic        accept_s;
   logic        check_s;
   logic        diverge_s;
   logic        win_clr_s;
   logic        trip_s;
   logic [3:0]  win_mis_upd_s;

   assign accept_s  = in_valid & in_ready_r;
   assign check_s   = (state_r == ST_CHECK);
   assign diverge_s = check_s &&
                      ((res_ref_r != res_dut_r) || (flags_ref_r != flags_dut_r));
   // Only a clear issued while the alarm is up touches the window.
   assign win_clr_s = (state_r == ST_ALARM) && alarm_clr;
   assign trip_s    = (win_mis_upd_s >= 4'(THRESHOLD));

   alu_mon_window #(
      .WINDOW (WINDOW)
   ) u_window (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (win_clr_s),
      .sample_en   (check_s),
      .diverge     (diverge_s),
      .win_mis_upd (win_mis_upd_s)
   );

   // Monitor FSM with registered handshake, alarm, pulse and totals.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r          <= ST_IDLE;
         in_ready_r       <= 1'b1;
         alarm_r          <= 1'b0;
         mismatch_pulse_r <= 1'b0;
         mismatch_total_r <= 8'd0;
         sample_total_r   <= 16'd0;
         a_r              <= 4'd0;
         b_r              <= 4'd0;
         op_r             <= 2'd0;
         res_ref_r        <= 4'd0;
         res_dut_r        <= 4'd0;
         flags_ref_r      <= '0;
         flags_dut_r      <= '0;
      end else begin
         mismatch_pulse_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  a_r         <= A;
                  b_r         <= B;
                  op_r        <= op;
                  res_ref_r   <= result_ref;
                  res_dut_r   <= result_dut;
                  flags_ref_r <= flags_t'(flags_ref);
                  flags_dut_r <= flags_t'(flags_dut);
                  state_r     <= ST_CHECK;
                  in_ready_r  <= 1'b0;
               end
            end
            ST_CHECK: begin
               sample_total_r   <= sample_total_r + 16'd1;
               mismatch_pulse_r <= diverge_s;
               if (diverge_s && (mismatch_total_r != 8'hFF)) begin
                  mismatch_total_r <= mismatch_total_r + 8'd1;
               end
               if (trip_s) begin
                  state_r    <= ST_ALARM;
                  alarm_r    <= 1'b1;
                  in_ready_r <= 1'b0;
               end else begin
                  state_r    <= ST_IDLE;
                  in_ready_r <= 1'b1;
               end
            end
            ST_ALARM: begin
               if (alarm_clr) begin
                  state_r    <= ST_IDLE;
                  alarm_r    <= 1'b0;
                  in_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               alarm_r    <= 1'b0;
               in_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready       = in_ready_r;
   assign alarm          = alarm_r;
   assign mismatch_pulse = mismatch_pulse_r;
   assign mismatch_total = mismatch_total_r;
   assign sample_total   = sample_total_r;

`ifdef ALU_MON_LOG_EN
   logic       log_valid_r;
   logic [3:0] log_a_r;
   logic [3:0] log_b_r;
   logic [1:0] log_op_r;

   // First divergence since reset is recorded and held; alarm_clr leaves it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         log_valid_r <= 1'b0;
         log_a_r     <= 4'd0;
         log_b_r     <= 4'd0;
         log_op_r    <= 2'd0;
      end else if (diverge_s && !log_valid_r) begin
         log_valid_r <= 1'b1;
         log_a_r     <= a_r;
         log_b_r     <= b_r;
         log_op_r    <= op_r;
      end
   end

   assign log_valid = log_valid_r;
   assign log_A     = log_a_r;
   assign log_B     = log_b_r;
   assign log_op    = log_op_r;
`else
   logic sample_unused_s;
   assign sample_unused_s = ^{a_r, b_r, op_r};

   assign log_valid = 1'b0;
   assign log_A     = 4'd0;
   assign log_B     = 4'd0;
   assign log_op    = 2'd0;
`endif

endmodule

// File: tb/tb_alu_divergence_monitor.sv
// Self-checking bench for alu_divergence_monitor (THRESHOLD=4, WINDOW=8).
// A behavioural model tracks totals, window position/mismatch count, alarm
// and the first-divergence record from the monitor's rules.
module tb_alu_divergence_monitor;

   localparam int THR = 4;
   localparam int WIN = 8;
`ifdef ALU_MON_LOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  A = 4'd0, B = 4'd0;
   logic [1:0]  op = 2'd0;
   logic [3:0]  result_ref = 4'd0, result_dut = 4'd0;
   logic [2:0]  flags_ref = 3'd0, flags_dut = 3'd0;
   logic        alarm_clr = 1'b0;
   logic        mismatch_pulse;
   logic        alarm;
   logic [7:0]  mismatch_total;
   logic [15:0] sample_total;
   logic        log_valid;
   logic [3:0]  log_A, log_B;
   logic [1:0]  log_op;

   int checks = 0;
   int errors = 0;

   // reference model state
   int         m_sample_total, m_mis_total, m_win_pos, m_win_mis;
   bit         m_alarm;
   bit         m_log_valid;
   logic [3:0] m_log_a, m_log_b;
   logic [1:0] m_log_op;

   alu_divergence_monitor #(.THRESHOLD(THR), .WINDOW(WIN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op(op), .result_ref(result_ref), .result_dut(result_dut),
      .flags_ref(flags_ref), .flags_dut(flags_dut), .alarm_clr(alarm_clr),
      .mismatch_pulse(mismatch_pulse), .alarm(alarm),
      .mismatch_total(mismatch_total), .sample_total(sample_total),
      .log_valid(log_valid), .log_A(log_A), .log_B(log_B), .log_op(log_op)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_sample_total = 0; m_mis_total = 0; m_win_pos = 0; m_win_mis = 0;
      m_alarm = 1'b0; m_log_valid = 1'b0;
      m_log_a = 4'd0; m_log_b = 4'd0; m_log_op = 2'd0;
   endtask

   task automatic model_sample(input bit div, input logic [3:0] a, input logic [3:0] b,
                               input logic [1:0] o);
      m_sample_total = (m_sample_total + 1) % 65536;
      if (div) begin
         if (m_mis_total < 255) m_mis_total++;
         if (m_win_mis < 15) m_win_mis++;
         if (!m_log_valid) begin
            m_log_valid = 1'b1; m_log_a = a; m_log_b = b; m_log_op = o;
         end
      end
      m_alarm = (m_win_mis >= THR);
      if (m_win_pos == WIN - 1) m_win_mis = 0;
      m_win_pos = (m_win_pos + 1) % WIN;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; alarm_clr = 1'b0; rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   // One sample through the handshake, checked one edge after acceptance.
   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                       input logic [3:0] rr, input logic [3:0] rd,
                       input logic [2:0] fr, input logic [2:0] fd);
      int n;
      bit div;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL send_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
         return;
      end
      A = a; B = b; op = o; result_ref = rr; result_dut = rd;
      flags_ref = fr; flags_dut = fd; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || mismatch_pulse !== 1'b0) begin
         errors++;
         $display("FAIL check_state: in_ready=%0b pulse=%0b required 0/0", in_ready, mismatch_pulse);
      end
      div = (rr != rd) || (fr != fd);
      model_sample(div, a, b, o);
      @(negedge clk);
      checks++;
      if (mismatch_pulse !== div || sample_total !== 16'(m_sample_total) ||
          mismatch_total !== 8'(m_mis_total) || alarm !== m_alarm || in_ready !== !m_alarm) begin
         errors++;
         $display("FAIL sample_result: pulse=%0b st=%0d mt=%0d alarm=%0b rdy=%0b required %0b %0d %0d %0b %0b",
                  mismatch_pulse, sample_total, mismatch_total, alarm, in_ready,
                  div, m_sample_total, m_mis_total, m_alarm, !m_alarm);
      end
      checks++;
      if (log_valid !== (LOG_EN & m_log_valid) || log_A !== (LOG_EN ? m_log_a : 4'd0) ||
          log_B !== (LOG_EN ? m_log_b : 4'd0) || log_op !== (LOG_EN ? m_log_op : 2'd0)) begin
         errors++;
         $display("FAIL log_record: v=%0b A=%0d B=%0d op=%0d required v=%0b A=%0d B=%0d op=%0d",
                  log_valid, log_A, log_B, log_op, LOG_EN & m_log_valid,
                  LOG_EN ? m_log_a : 4'd0, LOG_EN ? m_log_b : 4'd0, LOG_EN ? m_log_op : 2'd0);
      end
      @(negedge clk);
      checks++;
      if (mismatch_pulse !== 1'b0) begin
         errors++;
         $display("FAIL pulse_width: pulse=%0b required 0 two edges after accept", mismatch_pulse);
      end
   endtask

   task automatic clear_alarm();
      alarm_clr = 1'b1;
      @(negedge clk);
      alarm_clr = 1'b0;
      m_alarm = 1'b0; m_win_mis = 0; m_win_pos = 0;
      checks++;
      if (alarm !== 1'b0 || in_ready !== 1'b1 || mismatch_total !== 8'(m_mis_total)) begin
         errors++;
         $display("FAIL alarm_clear: alarm=%0b rdy=%0b mt=%0d required 0 1 %0d",
                  alarm, in_ready, mismatch_total, m_mis_total);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (in_ready !== 1'b1 || alarm !== 1'b0 || mismatch_pulse !== 1'b0 ||
          mismatch_total !== 8'd0 || sample_total !== 16'd0 || log_valid !== 1'b0 ||
          log_A !== 4'd0 || log_B !== 4'd0 || log_op !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: rdy=%0b alarm=%0b pulse=%0b mt=%0d st=%0d log=%0b required 1 0 0 0 0 0",
                  in_ready, alarm, mismatch_pulse, mismatch_total, sample_total, log_valid);
      end
   endtask

   task automatic test_matching();
      for (int i = 0; i < 10; i++) send(4'd3, 4'd5, 2'd0, 4'd8, 4'd8, 3'b000, 3'b000);
      checks++;
      if (sample_total !== 16'd10 || mismatch_total !== 8'd0 || alarm !== 1'b0) begin
         errors++;
         $display("FAIL matching_x10: st=%0d mt=%0d alarm=%0b required 10 0 0",
                  sample_total, mismatch_total, alarm);
      end
   endtask

   task automatic test_single_mismatch();
      send(4'd3, 4'd5, 2'd0, 4'd8, 4'd9, 3'b000, 3'b000);
      checks++;
      if (mismatch_total !== 8'd1 || (LOG_EN && (log_A !== 4'd3 || log_B !== 4'd5 || log_op !== 2'd0))) begin
         errors++;
         $display("FAIL single_mismatch: mt=%0d logA=%0d logB=%0d logop=%0d required 1 3 5 0",
                  mismatch_total, log_A, log_B, log_op);
      end
   endtask

   task automatic test_flag_alarm();
      int st;
      do_reset();
      for (int i = 0; i < 4; i++) send(4'd1, 4'd2, 2'd1, 4'd3, 4'd3, 3'b000, 3'b001);
      checks++;
      if (alarm !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flag_alarm: alarm=%0b rdy=%0b required 1 0", alarm, in_ready);
      end
      // inputs offered while the alarm is up must be ignored
      st = m_sample_total;
      A = 4'd7; B = 4'd7; result_ref = 4'd1; result_dut = 4'd2; in_valid = 1'b1;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (sample_total !== 16'(st) || alarm !== 1'b1 || mismatch_total !== 8'(m_mis_total)) begin
         errors++;
         $display("FAIL alarm_frozen: st=%0d alarm=%0b mt=%0d required %0d 1 %0d",
                  sample_total, alarm, mismatch_total, st, m_mis_total);
      end
      clear_alarm();
   endtask

   task automatic test_clr_outside_alarm();
      for (int i = 0; i < 3; i++) send(4'd2, 4'd2, 2'd2, 4'd4, 4'd5, 3'b010, 3'b010);
      alarm_clr = 1'b1;
      @(negedge clk);
      alarm_clr = 1'b0;
      checks++;
      if (alarm !== 1'b0 || in_ready !== 1'b1 || mismatch_total !== 8'(m_mis_total)) begin
         errors++;
         $display("FAIL clr_in_idle: alarm=%0b rdy=%0b mt=%0d required 0 1 %0d",
                  alarm, in_ready, mismatch_total, m_mis_total);
      end
      // window count must have survived the stray clear: one more trips
      send(4'd2, 4'd2, 2'd2, 4'd4, 4'd5, 3'b010, 3'b010);
      checks++;
      if (alarm !== 1'b1) begin
         errors++;
         $display("FAIL clr_no_effect: alarm=%0b required 1", alarm);
      end
      clear_alarm();
   endtask

   task automatic test_window_wrap();
      do_reset();
      for (int i = 0; i < 3; i++) send(4'd1, 4'd1, 2'd0, 4'd2, 4'd3, 3'b000, 3'b000);
      for (int i = 0; i < 5; i++) send(4'd1, 4'd1, 2'd0, 4'd2, 4'd2, 3'b000, 3'b000);
      for (int i = 0; i < 3; i++) send(4'd1, 4'd1, 2'd0, 4'd2, 4'd3, 3'b000, 3'b000);
      checks++;
      if (alarm !== 1'b0) begin
         errors++;
         $display("FAIL window_wrap: alarm=%0b required 0", alarm);
      end
      // fill to the last slot of this window, whose divergence hits threshold
      for (int i = 0; i < 4; i++) send(4'd1, 4'd1, 2'd0, 4'd2, 4'd2, 3'b000, 3'b000);
      send(4'd1, 4'd1, 2'd0, 4'd2, 4'd3, 3'b000, 3'b000);
      checks++;
      if (alarm !== 1'b1) begin
         errors++;
         $display("FAIL last_of_window_trip: alarm=%0b required 1", alarm);
      end
      clear_alarm();
   endtask

   task automatic test_reset_mid_check();
      A = 4'd9; B = 4'd9; op = 2'd3; result_ref = 4'd1; result_dut = 4'd0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (mismatch_pulse !== 1'b0 || sample_total !== 16'd0 || mismatch_total !== 8'd0 ||
          alarm !== 1'b0 || log_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_check: pulse=%0b st=%0d mt=%0d alarm=%0b log=%0b required all 0",
                  mismatch_pulse, sample_total, mismatch_total, alarm, log_valid);
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || sample_total !== 16'd0) begin
         errors++;
         $display("FAIL reset_release: rdy=%0b st=%0d required 1 0", in_ready, sample_total);
      end
      // reset while alarmed
      for (int i = 0; i < 4; i++) send(4'd5, 4'd6, 2'd1, 4'd0, 4'd15, 3'b100, 3'b100);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      checks++;
      if (alarm !== 1'b0 || in_ready !== 1'b1 || mismatch_total !== 8'd0 || sample_total !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_alarm: alarm=%0b rdy=%0b mt=%0d st=%0d required 0 1 0 0",
                  alarm, in_ready, mismatch_total, sample_total);
      end
   endtask

   task automatic test_random();
      logic [3:0] a, b, rr, rd;
      logic [1:0] o;
      logic [2:0] fr, fd;
      for (int i = 0; i < 80; i++) begin
         a = 4'($urandom); b = 4'($urandom); o = 2'($urandom);
         rr = 4'($urandom); fr = 3'($urandom); rd = rr; fd = fr;
         if ($urandom_range(0, 9) < 3) begin
            if ($urandom_range(0, 1) == 0) rd = rr ^ 4'($urandom_range(1, 15));
            else fd = fr ^ 3'($urandom_range(1, 7));
         end
         send(a, b, o, rr, rd, fr, fd);
         if (m_alarm) clear_alarm();
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         send(4'd3, 4'd5, 2'd0, 4'd8, 4'd9, 3'b000, 3'b000);
         if (m_alarm) clear_alarm();
      end
      checks++;
      if (mismatch_total !== 8'd255 || sample_total !== 16'(m_sample_total)) begin
         errors++;
         $display("FAIL mismatch_saturate: mt=%0d st=%0d required 255 %0d",
                  mismatch_total, sample_total, m_sample_total);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_matching();
      test_single_mismatch();
      test_flag_alarm();
      test_clr_outside_alarm();
      test_window_wrap();
      test_reset_mid_check();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
